// File: rtl/loga_capture_ctrl_pkg.sv
// Shared definitions for the LOGA capture/readout sequencer.
//   - state_t          : sequencer state encoding (3 bits)
//   - DEF_ADDR_W/DATA_W: default sample memory geometry (64K x 8)
//   - FIFO_DEPTH       : entries in the readout FIFO
//   - state_is_busy()  : true while a capture or readout is in progress
package loga_capture_ctrl_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREFILL   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4,
        ST_READ      = 3'd5
    } state_t;

    function automatic logic state_is_busy(input state_t s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/loga_capture_ctrl_if.sv
// Bundle of all control, sample-RAM and host-stream signals of the capture
// sequencer.
//   master : the sequencer (drives RAM addresses, status and the output stream)
//   slave  : the environment (trigger logic, RAM read data, host)
interface loga_capture_ctrl_if
    import loga_capture_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    // capture control
    logic              arm;
    logic              abort;
    logic              trig_hit;
    logic [ADDR_W-1:0] pre_depth;
    logic [ADDR_W-1:0] post_depth;
    // sample RAM
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    // readout stream
    logic              rd_req;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    // status
    logic              busy;
    logic              triggered;
    logic [ADDR_W-1:0] trig_addr;

    modport master (
        input  arm, abort, trig_hit, pre_depth, post_depth, rd_data, rd_req, out_ready,
        output wr_en, wr_addr, rd_addr, out_data, out_valid, out_last,
               busy, triggered, trig_addr
    );

    modport slave (
        output arm, abort, trig_hit, pre_depth, post_depth, rd_data, rd_req, out_ready,
        input  wr_en, wr_addr, rd_addr, out_data, out_valid, out_last,
               busy, triggered, trig_addr
    );

endinterface

// File: rtl/loga_capture_ctrl_rd_fifo.sv
// Two-entry readout FIFO holding {last, data}.
//   clk, rst            : clock, asynchronous active-high reset
//   push/push_data/last : write one entry (ignored when full without pop)
//   pop                 : remove the head entry (ignored when empty)
//   flush               : empty the FIFO, has priority over push/pop
//   head_*              : current head entry; head_valid = not empty
//   count               : occupancy 0..2
module loga_capture_ctrl_rd_fifo
    import loga_capture_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic              head_valid,
    output logic [1:0]        count
);

    logic [DATA_W:0] entry [FIFO_DEPTH];
    logic            wr_ptr_reg;
    logic            rd_ptr_reg;
    logic [1:0]      count_reg;
    logic            push_ok;
    logic            pop_ok;

    assign pop_ok  = pop && (count_reg != 2'd0);
    assign push_ok = push && ((count_reg != 2'd2) || pop_ok);

    // Storage is cleared on flush as well so an idle stream shows zero data.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [DATA_W:0] q_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_reg <= '0;
                end else if (flush) begin
                    q_reg <= '0;
                end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
                    q_reg <= {push_last, push_data};
                end
            end
            assign entry[gi] = q_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data  = entry[rd_ptr_reg][DATA_W-1:0];
    assign head_last  = entry[rd_ptr_reg][DATA_W];
    assign head_valid = (count_reg != 2'd0);
    assign count      = count_reg;

endmodule

// File: rtl/loga_capture_ctrl.sv
// Capture/readout sequencer for the LOGA sample memory.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : loga_capture_ctrl_if.master -- arm/abort/trigger control,
//              sample RAM write/read addresses and read data, readout
//              stream (out_data/out_valid/out_last/out_ready) and status.
// A capture fills a ring buffer with pre_depth samples, waits for a trigger,
// then records post_depth more. Readout streams the window oldest first.
module loga_capture_ctrl
    import loga_capture_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic                clk,
    input logic                rst,
    loga_capture_ctrl_if.master bus
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_reg;
    logic [ADDR_W-1:0] pre_reg;
    logic [ADDR_W-1:0] post_reg;        // post depth after clamping
    logic [ADDR_W-1:0] fill_cnt_reg;
    logic [ADDR_W-1:0] post_cnt_reg;
    logic [CNT_W-1:0]  rd_left_reg;     // reads still to be issued
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              triggered_reg;
    logic [ADDR_W-1:0] trig_addr_reg;
    logic              in_flight_reg;   // RAM read issued last cycle
    logic              in_flight_last_reg;

    logic              depth_over;
    logic [ADDR_W-1:0] post_clamped;
    logic [CNT_W-1:0]  rd_len;
    logic [DATA_W-1:0] head_data;
    logic              head_last;
    logic              head_valid;
    logic [1:0]        fifo_count;
    logic [1:0]        occ_total;
    logic              pop;
    logic              issue;

    // Window never exceeds the memory: DEPTH-1-pre is simply ~pre.
    assign depth_over   = (CNT_W'(bus.pre_depth) + CNT_W'(bus.post_depth)) >= DEPTH;
    assign post_clamped = depth_over ? ~bus.pre_depth : bus.post_depth;
    assign rd_len       = CNT_W'(pre_reg) + CNT_W'(post_reg) + CNT_W'(1);

    // A read may be issued when the FIFO is guaranteed to have room for its
    // data one cycle later: occupancy + in_flight - pop < 2.
    assign pop       = head_valid && bus.out_ready;
    assign occ_total = fifo_count + {1'b0, in_flight_reg};
    assign issue     = (state_reg == ST_READ) && !bus.abort &&
                       (rd_left_reg != '0) && ((occ_total < 2'd2) || pop);

    loga_capture_ctrl_rd_fifo #(
        .DATA_W (DATA_W)
    ) u_rd_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (in_flight_reg),
        .push_data  (bus.rd_data),
        .push_last  (in_flight_last_reg),
        .pop        (pop),
        .flush      (bus.abort),
        .head_data  (head_data),
        .head_last  (head_last),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            pre_reg            <= '0;
            post_reg           <= '0;
            fill_cnt_reg       <= '0;
            post_cnt_reg       <= '0;
            rd_left_reg        <= '0;
            wr_en_reg          <= 1'b0;
            wr_addr_reg        <= '0;
            rd_addr_reg        <= '0;
            triggered_reg      <= 1'b0;
            trig_addr_reg      <= '0;
            in_flight_reg      <= 1'b0;
            in_flight_last_reg <= 1'b0;
        end else begin
            in_flight_reg      <= issue;
            in_flight_last_reg <= issue && (rd_left_reg == CNT_W'(1));
            if (issue) begin
                rd_addr_reg <= rd_addr_reg + ADDR_W'(1);
                rd_left_reg <= rd_left_reg - CNT_W'(1);
            end

            if (bus.abort) begin
                state_reg <= ST_IDLE;
                wr_en_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE, ST_DONE: begin
                        if (bus.arm) begin
                            pre_reg       <= bus.pre_depth;
                            post_reg      <= post_clamped;
                            fill_cnt_reg  <= '0;
                            post_cnt_reg  <= '0;
                            wr_addr_reg   <= '0;
                            triggered_reg <= 1'b0;
                            wr_en_reg     <= 1'b1;
                            state_reg     <= (bus.pre_depth == '0) ? ST_WAIT_TRIG : ST_PREFILL;
                        end else if ((state_reg == ST_DONE) && bus.rd_req) begin
                            rd_addr_reg <= trig_addr_reg - pre_reg;
                            rd_left_reg <= rd_len;
                            state_reg   <= ST_READ;
                        end
                    end
                    ST_PREFILL: begin
                        // trig_hit deliberately ignored until the pre-window is full
                        wr_addr_reg  <= wr_addr_reg + ADDR_W'(1);
                        fill_cnt_reg <= fill_cnt_reg + ADDR_W'(1);
                        if (fill_cnt_reg + ADDR_W'(1) == pre_reg) state_reg <= ST_WAIT_TRIG;
                    end
                    ST_WAIT_TRIG: begin
                        wr_addr_reg <= wr_addr_reg + ADDR_W'(1);
                        if (bus.trig_hit) begin
                            trig_addr_reg <= wr_addr_reg;
                            triggered_reg <= 1'b1;
                            if (post_reg == '0) begin
                                wr_en_reg <= 1'b0;
                                state_reg <= ST_DONE;
                            end else begin
                                state_reg <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        wr_addr_reg  <= wr_addr_reg + ADDR_W'(1);
                        post_cnt_reg <= post_cnt_reg + ADDR_W'(1);
                        if (post_cnt_reg + ADDR_W'(1) == post_reg) begin
                            wr_en_reg <= 1'b0;
                            state_reg <= ST_DONE;
                        end
                    end
                    ST_READ: begin
                        if (pop && head_last) state_reg <= ST_DONE;
                    end
                    default: begin
                        wr_en_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.wr_en     = wr_en_reg;
    assign bus.wr_addr   = wr_addr_reg;
    assign bus.rd_addr   = rd_addr_reg;
    assign bus.out_data  = head_data;
    assign bus.out_valid = head_valid;
    assign bus.out_last  = head_last;
    assign bus.busy      = state_is_busy(state_reg);
    assign bus.triggered = triggered_reg;
    assign bus.trig_addr = trig_addr_reg;

endmodule
